ipml_sync_fifo_v1_7: RTL and testbench

IPML_SYNC_FIFO_V1_7 -- requirements
Module: ipml_sync_fifo_v1_7

---
 rtl/ipml_sync_fifo_v1_7.sv | 132 +++++++++++++
 tb/tb_ipml_sync_fifo_v1_7.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipml_sync_fifo_v1_7.sv
// Single-clock FIFO with runtime almost-full/almost-empty thresholds, sticky
// overflow/underflow, and optional first-word-fall-through output stage.
module ipml_sync_fifo_v1_7 #(
   parameter int c_DATA_WIDTH  = 32,
   parameter int c_DEPTH_WIDTH = 9,
   parameter int c_FWFT        = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [c_DATA_WIDTH-1:0]  wr_data,
   output logic                     wr_full,
   output logic                     almost_full,
   input  logic                     rd_en,
   output logic [c_DATA_WIDTH-1:0]  rd_data,
   output logic                     rd_empty,
   output logic                     almost_empty,
   input  logic [c_DEPTH_WIDTH:0]   af_thresh,
   input  logic [c_DEPTH_WIDTH:0]   ae_thresh,
   output logic [c_DEPTH_WIDTH:0]   water_level,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int DW = c_DEPTH_WIDTH;
   localparam logic [DW:0]   DEPTH   = {1'b1, {DW{1'b0}}};
   localparam logic [DW:0]   LVL_ONE = {{DW{1'b0}}, 1'b1};
   localparam logic [DW-1:0] PTR_ONE = {{(DW-1){1'b0}}, 1'b1};

   logic [c_DATA_WIDTH-1:0] mem [0:(1<<DW)-1];
   logic [DW-1:0] wr_ptr, rd_ptr;
   logic [DW:0]   level, level_nxt, mem_cnt;
   logic          head_vld, head_nxt, armed;
   logic          wr_acc, rd_acc, mem_pop, load_head, bypass, empty_nxt;

   assign water_level = level;
   assign wr_acc      = wr_en & ~wr_full;
   assign rd_acc      = rd_en & ~rd_empty;
   // Words still in the array, excluding the one parked in the FWFT output register.
   assign mem_cnt     = level - {{DW{1'b0}}, head_vld};

   always_comb begin
      level_nxt = level;
      case ({wr_acc, rd_acc})
         2'b10:   level_nxt = level + LVL_ONE;
         2'b01:   level_nxt = level - LVL_ONE;
         default: level_nxt = level;
      endcase
   end

   always_comb begin
      mem_pop   = 1'b0;
      load_head = 1'b0;
      bypass    = 1'b0;
      head_nxt  = head_vld;
      if (c_FWFT != 0) begin
         if (rd_acc) begin
            if (mem_cnt != '0) begin
               mem_pop   = 1'b1;
               load_head = 1'b1;
            end else if (wr_acc) begin
               // Refill straight from the write port so a level-1 FIFO never blinks empty.
               mem_pop   = 1'b1;
               load_head = 1'b1;
               bypass    = 1'b1;
            end else begin
               head_nxt  = 1'b0;
            end
         end else if (!head_vld && armed && mem_cnt != '0) begin
            // armed lags the array count by one edge, giving the 2-cycle empty-write latency.
            mem_pop   = 1'b1;
            load_head = 1'b1;
            head_nxt  = 1'b1;
         end
         empty_nxt = ~head_nxt;
      end else begin
         mem_pop   = rd_acc;
         load_head = rd_acc;
         empty_nxt = (level_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !flush && wr_acc)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         head_vld     <= 1'b0;
         armed        <= 1'b0;
         wr_full      <= 1'b0;
         almost_full  <= 1'b0;
         rd_empty     <= 1'b1;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         rd_data      <= '0;
      end else if (flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         head_vld     <= 1'b0;
         armed        <= 1'b0;
         wr_full      <= 1'b0;
         almost_full  <= (af_thresh == '0);
         rd_empty     <= 1'b1;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (mem_pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (load_head)
            rd_data <= bypass ? wr_data : mem[rd_ptr];
         level        <= level_nxt;
         head_vld     <= head_nxt;
         armed        <= (mem_cnt != '0);
         wr_full      <= (level_nxt == DEPTH);
         almost_full  <= (level_nxt >= af_thresh);
         rd_empty     <= empty_nxt;
         almost_empty <= (level_nxt <= ae_thresh);
         overflow     <= overflow | (wr_en & wr_full);
         underflow    <= underflow | (rd_en & rd_empty);
      end
   end
endmodule

// File: tb/tb_ipml_sync_fifo_v1_7.sv
// Directed bench: standard-read instance (s_*) and FWFT instance (f_*), depth 16, shared stimulus.
module tb_ipml_sync_fifo_v1_7;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       flush = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic [4:0] af_thresh = 5'd14;
   logic [4:0] ae_thresh = 5'd2;

   logic       s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
   logic [7:0] s_data;
   logic [4:0] s_lvl;
   logic       f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
   logic [7:0] f_data;
   logic [4:0] f_lvl;

   int n_assert = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ipml_sync_fifo_v1_7 #(.c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT(0)) dut_std (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_full(s_full), .almost_full(s_af), .rd_en(rd_en), .rd_data(s_data),
      .rd_empty(s_empty), .almost_empty(s_ae), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .water_level(s_lvl), .overflow(s_ovf), .underflow(s_unf));

   ipml_sync_fifo_v1_7 #(.c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT(1)) dut_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_full(f_full), .almost_full(f_af), .rd_en(rd_en), .rd_data(f_data),
      .rd_empty(f_empty), .almost_empty(f_ae), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .water_level(f_lvl), .overflow(f_ovf), .underflow(f_unf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int got;
      bit started;

      // asynchronous reset, checked before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_s_empty", s_empty, 1);
      chk("rst_s_full", s_full, 0);
      chk("rst_s_lvl", s_lvl, 0);
      chk("rst_s_ae", s_ae, 1);
      chk("rst_s_af", s_af, 0);
      chk("rst_s_data", s_data, 0);
      chk("rst_f_empty", f_empty, 1);
      chk("rst_f_data", f_data, 0);
      step();
      step();
      rst_n = 1'b1;

      // fill 16 words, standard mode
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1;
         wr_data = 8'(i);
         step();
         chk("fill_lvl", s_lvl, i + 1);
         chk("fill_af", s_af, (i + 1 >= 14) ? 1 : 0);
         chk("fill_ae", s_ae, (i + 1 <= 2) ? 1 : 0);
         chk("fill_full", s_full, (i == 15) ? 1 : 0);
      end
      wr_data = 8'hEE;
      step();
      wr_en = 1'b0;
      chk("ovf_set", s_ovf, 1);
      chk("ovf_lvl", s_lvl, 16);
      chk("ovf_full", s_full, 1);

      // drain 16 words in order
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1;
         step();
         chk("drain_data", s_data, i);
         chk("drain_lvl", s_lvl, 15 - i);
         chk("drain_empty", s_empty, (i == 15) ? 1 : 0);
      end
      step();
      rd_en = 1'b0;
      chk("unf_set", s_unf, 1);
      chk("unf_data_hold", s_data, 8'h0F);

      // flush clears sticky flags, rd_data holds
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_ovf", s_ovf, 0);
      chk("flush_unf", s_unf, 0);
      chk("flush_data_hold", s_data, 8'h0F);

      // simultaneous write/read at empty
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h40;
      step();
      rd_en = 1'b0;
      chk("wr_rd_empty_lvl", s_lvl, 1);
      chk("wr_rd_empty_unf", s_unf, 1);
      chk("wr_rd_empty_data", s_data, 8'h0F);
      chk("wr_rd_empty_flag", s_empty, 0);
      for (int i = 1; i < 16; i++) begin
         wr_data = 8'(8'h40 + i);
         step();
      end
      chk("refill_full", s_full, 1);

      // simultaneous write/read at full
      rd_en = 1'b1; wr_data = 8'hFF;
      step();
      wr_en = 1'b0;
      chk("wr_rd_full_lvl", s_lvl, 15);
      chk("wr_rd_full_ovf", s_ovf, 1);
      chk("wr_rd_full_data", s_data, 8'h40);
      chk("wr_rd_full_flag", s_full, 0);
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("read6_data", s_data, 8'h40 + i);
      end
      rd_en = 1'b0;
      chk("pre_flush_lvl", s_lvl, 9);

      // flush at level 9 with a concurrent write
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
      step();
      flush = 1'b0; wr_en = 1'b0;
      chk("flush9_lvl", s_lvl, 0);
      chk("flush9_empty", s_empty, 1);
      chk("flush9_ovf", s_ovf, 0);
      chk("flush9_unf", s_unf, 0);
      chk("flush9_data", s_data, 8'h46);
      wr_en = 1'b1; wr_data = 8'h77;
      step();
      wr_en = 1'b0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("post_flush_data", s_data, 8'h77);
      chk("post_flush_lvl", s_lvl, 0);

      // threshold overrides
      af_thresh = 5'd0; ae_thresh = 5'd16;
      step();
      chk("af0_force", s_af, 1);
      for (int i = 0; i < 7; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h10 + i);
         step();
      end
      wr_en = 1'b0;
      chk("ae16_force", s_ae, 1);
      chk("af0_force_l7", s_af, 1);
      af_thresh = 5'd14; ae_thresh = 5'd2;
      step();
      chk("thr_restore_af", s_af, 0);
      chk("thr_restore_ae", s_ae, 0);
      chk("lvl7", s_lvl, 7);

      // reset pulse between edges at level 7
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_lvl", s_lvl, 0);
      chk("midrst_empty", s_empty, 1);
      chk("midrst_data", s_data, 0);
      chk("midrst_ae", s_ae, 1);
      step();
      rst_n = 1'b1;
      wr_en = 1'b1; wr_data = 8'hC0;
      step();
      wr_en = 1'b0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("postrst_data", s_data, 8'hC0);
      chk("postrst_lvl", s_lvl, 0);

      // FWFT: clean start, single write latency
      flush = 1'b1;
      step();
      flush = 1'b0;
      wr_en = 1'b1; wr_data = 8'hA5;
      step();
      wr_en = 1'b0;
      chk("fwft_e0_empty", f_empty, 1);
      chk("fwft_e0_lvl", f_lvl, 1);
      step();
      chk("fwft_e1_empty", f_empty, 1);
      step();
      chk("fwft_e2_empty", f_empty, 0);
      chk("fwft_e2_data", f_data, 8'hA5);

      // write+read at level 1 keeps rd_empty low
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
      step();
      chk("fwft_l1_empty", f_empty, 0);
      chk("fwft_l1_data", f_data, 8'h5A);
      chk("fwft_l1_lvl", f_lvl, 1);
      wr_data = 8'h5B;
      step();
      chk("fwft_l1b_data", f_data, 8'h5B);
      wr_en = 1'b0;
      step();
      chk("fwft_pop_last_empty", f_empty, 1);
      chk("fwft_pop_last_lvl", f_lvl, 0);

      // 40-word stream with rd_en held high
      got = 0;
      started = 1'b0;
      rd_en = 1'b1;
      for (int cyc = 0; cyc < 48; cyc++) begin
         wr_en = (cyc < 40);
         wr_data = 8'(cyc);
         step();
         if (!started && !f_empty) begin
            started = 1'b1;
            chk("stream_first_cyc", cyc, 2);
         end
         if (started && got < 40) begin
            chk("stream_no_bubble", f_empty, 0);
            chk("stream_data", f_data, got);
            got++;
         end
      end
      rd_en = 1'b0; wr_en = 1'b0;
      chk("stream_count", got, 40);
      chk("stream_end_empty", f_empty, 1);
      chk("stream_end_lvl", f_lvl, 0);

      // FWFT full with simultaneous write/read
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h20 + i);
         step();
      end
      chk("fwft_full", f_full, 1);
      chk("fwft_full_af", f_af, 1);
      rd_en = 1'b1; wr_data = 8'hFF;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("fwft_wr_rd_full_lvl", f_lvl, 15);
      chk("fwft_wr_rd_full_ovf", f_ovf, 1);
      chk("fwft_wr_rd_full_data", f_data, 8'h21);

      // FWFT empty with simultaneous write/read
      flush = 1'b1;
      step();
      flush = 1'b0;
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h33;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("fwft_wr_rd_empty_lvl", f_lvl, 1);
      chk("fwft_wr_rd_empty_unf", f_unf, 1);
      step();
      step();
      chk("fwft_wr_rd_empty_data", f_data, 8'h33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
